imem_responder: RTL and testbench
=================================

# imem_responder

Instruction-memory responder serving the fetch stage's PC requests over a valid/ready request channel and a valid/ready response channel. It holds the program in a word-addressed synchronous-read array, returns instructions after a fixed pipeline latency, and flags misaligned or out-of-range fetches. A side write port loads the program before or between runs. A flush input discards in-flight responses on a branch/jump/interrupt redirect.

## Interface
- DEPTH_WORDS, 4096: instruction words stored (power of two)
- BASE_ADDR, 32'h0000_0000: byte address of word 0
- READ_LATENCY, 2: cycles from request accept to earliest response (legal 1..4)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  fetch presents a PC
- req_ready  out  1  responder accepts this cycle
- req_addr  in  32  byte address (PC)
- flush  in  1  redirect; drop all in-flight and buffered responses
- rsp_valid  out  1  response available
- rsp_ready  in  1  fetch consumes response (deasserted when fetch stalls)
- rsp_instr  out  32  instruction word; NOP_INSTR on error
- rsp_addr  out  32  echo of the request address
- rsp_err  out  2  error code: 0 none, 1 misaligned, 2 out of range
- load_en  in  1  program-load write strobe
- load_addr  in  32  byte address of loaded word
- load_data  in  32  word to write

## Operation
- Request accepted when req_valid && req_ready; one request per cycle max.
- req_ready = !rst && !load_en && (in_flight + buffered) < READ_LATENCY + 1 (credit count; responses are never lost under backpressure).
- Error check at accept: req_addr[1:0] != 0 -> err 1; else (req_addr - BASE_ADDR) >> 2 >= DEPTH_WORDS or req_addr < BASE_ADDR -> err 2. Error responses carry rsp_instr = NOP_INSTR (32'h0000_0013) and do not read the array.
- Index = (req_addr - BASE_ADDR)[log2(DEPTH_WORDS)+1:2]; subtraction done in 32 bits, no wrap allowed (underflow is err 2).
- Read pipeline: READ_LATENCY stages carrying {valid, addr, err}; array data joins at its stage; last stage pushes into output FIFO (depth READ_LATENCY + 1).
- Responses delivered strictly in request order. rsp_* held stable while rsp_valid && !rsp_ready.
- flush: at the edge, clears all pipeline valid bits and empties the FIFO; credit count returns to zero. A request accepted in the same cycle as flush is kept (it is the redirected PC).
- load_en: writes load_data at the load_addr index in that cycle; misaligned/out-of-range loads are ignored. A read accepted the cycle after a write returns the new data. load_en has priority over requests (req_ready low).
- Array contents are not reset.

## Timing
- Reset values: req_ready 0 (1 from first edge after rst falls), rsp_valid 0, rsp_instr NOP_INSTR, rsp_addr 0, rsp_err 0; pipeline and FIFO empty.
- Reset asserted mid-operation: all in-flight requests discarded immediately (asynchronously); no response emitted for them.
- Latency: accept at edge T -> rsp_valid high after edge T + READ_LATENCY when FIFO was empty; FIFO bypass required to meet this.
- Throughput: one response per cycle with rsp_ready held high.
- Full: with rsp_ready low, exactly READ_LATENCY + 1 requests accepted, then req_ready low until a response is consumed; req_ready rises the cycle after the consuming edge.
- Simultaneous push and pop on a full FIFO: allowed, occupancy unchanged.

## Structure
- Package imem_pkg: NOP_INSTR constant, imem_err_t enum (ERR_NONE, ERR_MISALIGNED, ERR_RANGE), imem_rsp_t struct {addr, instr, err}.
- Sub-module imem_rsp_fifo: parameterised-depth synchronous FIFO of imem_rsp_t with flush, count, full/empty.

## Test plan
- Load words 0x00500093, 0x00A00113 at 0x0, 0x4; request 0x0, 0x4 back-to-back, rsp_ready=1 -> responses at T+2, T+3 with those words, err 0.
- Request 0x2 -> rsp_err 1, rsp_instr 0x00000013; request 0x4000 (DEPTH_WORDS=4096) -> rsp_err 2.
- rsp_ready=0, stream requests -> exactly 3 accepted (READ_LATENCY=2), req_ready low; raise rsp_ready -> three responses in order, no drops or duplicates.
- Two requests in flight, assert flush with new request 0x40 -> only response for 0x40 appears.
- Assert rst mid-stream with responses pending -> rsp_valid falls immediately; after release, no stale response; first new request returns correct data.
- Write 0xDEADBEEF to 0x8 then read 0x8 next cycle -> 0xDEADBEEF; req_ready low during load_en.

Source files
------------

// File: rtl/imem_responder_pkg.sv
// Shared types and helpers for the instruction-memory responder.
package imem_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_MISALIGNED = 2'd1,
    ERR_RANGE      = 2'd2
  } imem_err_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    imem_err_t   err;
  } imem_rsp_t;

  // What the response port shows when nothing is buffered.
  localparam imem_rsp_t RSP_IDLE = '{addr: 32'h0, instr: NOP_INSTR, err: ERR_NONE};

  // Classify a byte address; misalignment wins over range, and an address
  // below the base is out of range rather than wrapping.
  function automatic imem_err_t checkAddr(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] depthWords);
    logic [31:0] offset;
    offset = addr - base;
    if (addr[1:0] != 2'b00) return ERR_MISALIGNED;
    if ((addr < base) || ((offset >> 2) >= depthWords)) return ERR_RANGE;
    return ERR_NONE;
  endfunction

  // Word index relative to the base; callers truncate to the array width.
  function automatic logic [31:0] wordIndex(input logic [31:0] addr,
                                            input logic [31:0] base);
    logic [31:0] offset;
    offset = addr - base;
    return offset >> 2;
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Request, response and program-load channels between fetch and the responder.
interface imem_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        flush;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic [1:0]  rsp_err;

  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  modport master (
    output req_valid, req_addr, flush, rsp_ready, load_en, load_addr, load_data,
    input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, flush, rsp_ready, load_en, load_addr, load_data,
    output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );

endinterface

// File: rtl/imem_responder_rsp_fifo.sv
// Small circular FIFO of responses with flush, occupancy count and full/empty.
module imem_rsp_fifo
  import imem_pkg::*;
#(
  parameter  int DEPTH = 3,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  imem_rsp_t        pushData_i,
  input  logic             pop_i,
  output imem_rsp_t        headData_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  imem_rsp_t        entries_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush;
  logic             doPop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign headData_o = entries_q[rdPtr_q];
  assign doPop      = pop_i && !empty_o;
  assign doPush     = push_i && (!full_o || doPop);

  // Pointer and occupancy next-state; a push and pop together leave the count alone.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = nextPtr(wrPtr_q);
    if (doPop)  rdPtr_d = nextPtr(rdPtr_q);
    if (doPush && !doPop)      count_d = count_q + CNT_W'(1);
    else if (!doPush && doPop) count_d = count_q - CNT_W'(1);
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end
  end

  // Control state, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; only occupied slots are ever observed.
  always_ff @(posedge clk) begin
    if (doPush) entries_q[wrPtr_q] <= pushData_i;
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: synchronous-read program array behind a
// fixed-latency pipeline and a credit-protected response FIFO.
module imem_responder
  import imem_pkg::*;
#(
  parameter int          DEPTH_WORDS  = 4096,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          READ_LATENCY = 2
) (
  input logic  clk,
  input logic  rst,
  imem_if.slave bus
);

  localparam int IDX_W      = $clog2(DEPTH_WORDS);
  localparam int FIFO_DEPTH = READ_LATENCY + 1;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CREDIT_W   = $clog2(2 * READ_LATENCY + 2);

  logic [31:0]           memArray_q [DEPTH_WORDS];
  logic [31:0]           readData_q;
  logic [31:0]           lastInstr;

  logic [READ_LATENCY-1:0] stageValid_q;
  logic [31:0]             stageAddr_q [READ_LATENCY];
  imem_err_t               stageErr_q  [READ_LATENCY];

  logic                  readyEn_q;
  logic                  accept;
  logic                  pop;
  logic                  push;
  imem_err_t             reqErr;
  imem_err_t             loadErr;
  logic                  loadWrite;
  logic [IDX_W-1:0]      reqIdx;
  logic [IDX_W-1:0]      loadIdx;
  logic [CREDIT_W-1:0]   inFlight;
  logic [CREDIT_W-1:0]   credit;
  imem_rsp_t             pushData;
  imem_rsp_t             headData;
  imem_rsp_t             rspView;
  logic [FIFO_CNT_W-1:0] fifoCount;
  logic                  fifoFull;
  logic                  fifoEmpty;

  assign reqErr    = checkAddr(bus.req_addr, BASE_ADDR, 32'(DEPTH_WORDS));
  assign loadErr   = checkAddr(bus.load_addr, BASE_ADDR, 32'(DEPTH_WORDS));
  assign reqIdx    = IDX_W'(wordIndex(bus.req_addr, BASE_ADDR));
  assign loadIdx   = IDX_W'(wordIndex(bus.load_addr, BASE_ADDR));
  assign loadWrite = bus.load_en && (loadErr == ERR_NONE);

  // Count requests still travelling through the read pipeline.
  always_comb begin
    inFlight = '0;
    for (int k = 0; k < READ_LATENCY; k++) inFlight = inFlight + CREDIT_W'(stageValid_q[k]);
  end

  assign credit = inFlight + CREDIT_W'(fifoCount);

  assign bus.req_ready = readyEn_q && !rst && !bus.load_en && !fifoFull &&
                         (credit < CREDIT_W'(FIFO_DEPTH));
  assign accept        = bus.req_valid && bus.req_ready;
  assign pop           = !fifoEmpty && bus.rsp_ready;

  // Hold off requests until the first clock edge after reset releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) readyEn_q <= 1'b0;
    else     readyEn_q <= 1'b1;
  end

  // Program array write port and synchronous read for accepted good requests.
  always_ff @(posedge clk) begin
    if (loadWrite) memArray_q[loadIdx] <= bus.load_data;
    if (accept && (reqErr == ERR_NONE)) readData_q <= memArray_q[reqIdx];
  end

  // Valid bits of the read pipeline; flush drops everything except this cycle's request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stageValid_q <= '0;
    end else begin
      stageValid_q[0] <= accept;
      for (int k = 1; k < READ_LATENCY; k++)
        stageValid_q[k] <= bus.flush ? 1'b0 : stageValid_q[k-1];
    end
  end

  // Address and error code ride alongside the valid bits.
  always_ff @(posedge clk) begin
    stageAddr_q[0] <= bus.req_addr;
    stageErr_q[0]  <= reqErr;
    for (int k = 1; k < READ_LATENCY; k++) begin
      stageAddr_q[k] <= stageAddr_q[k-1];
      stageErr_q[k]  <= stageErr_q[k-1];
    end
  end

  // Read data joins one stage in and is delayed to line up with the last stage.
  if (READ_LATENCY > 1) begin : gInstrPipe
    logic [31:0] instrPipe_q [1:READ_LATENCY-1];
    // Shift the array word along the remaining stages.
    always_ff @(posedge clk) begin
      instrPipe_q[1] <= readData_q;
      for (int k = 2; k < READ_LATENCY; k++) instrPipe_q[k] <= instrPipe_q[k-1];
    end
    assign lastInstr = instrPipe_q[READ_LATENCY-1];
  end else begin : gNoPipe
    assign lastInstr = readData_q;
  end

  // Build the response leaving the pipeline; errors never expose array data.
  always_comb begin
    pushData.addr  = stageAddr_q[READ_LATENCY-1];
    pushData.err   = stageErr_q[READ_LATENCY-1];
    pushData.instr = (stageErr_q[READ_LATENCY-1] != ERR_NONE) ? NOP_INSTR : lastInstr;
  end

  assign push = stageValid_q[READ_LATENCY-1] && !bus.flush;

  imem_rsp_fifo #(.DEPTH(FIFO_DEPTH)) rspFifo (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (bus.flush),
    .push_i     (push),
    .pushData_i (pushData),
    .pop_i      (pop),
    .headData_o (headData),
    .count_o    (fifoCount),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty)
  );

  // Show idle values whenever the FIFO has nothing to offer.
  always_comb begin
    rspView = headData;
    if (fifoEmpty) rspView = RSP_IDLE;
  end

  assign bus.rsp_valid = !fifoEmpty;
  assign bus.rsp_instr = rspView.instr;
  assign bus.rsp_addr  = rspView.addr;
  assign bus.rsp_err   = rspView.err;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: table of single fetches plus
// hand-written backpressure, flush, reset and load-then-read sequences.
module tb_imem_responder;
  import imem_pkg::*;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  imem_if bus();

  imem_responder #(
    .DEPTH_WORDS (4096),
    .BASE_ADDR   (32'h0000_0000),
    .READ_LATENCY(LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] expInstr;
    logic [31:0] expErr;
    string       name;
  } vector_t;

  vector_t vectors [9];

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  task automatic loadWord(input logic [31:0] a, input logic [31:0] d);
    bus.load_en   = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    tick();
    bus.load_en   = 1'b0;
  endtask

  // Issue one fetch with rsp_ready high and check its timing and contents.
  task automatic applyStimulus(input vector_t v);
    bus.req_valid = 1'b1;
    bus.req_addr  = v.addr;
    bus.rsp_ready = 1'b1;
    #1;
    checkOutput({v.name, " req_ready"}, 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    repeat (LAT - 1) tick();
    checkOutput({v.name, " not early"}, 32'(bus.rsp_valid), 32'd0);
    tick();
    checkOutput({v.name, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    checkOutput({v.name, " rsp_instr"}, bus.rsp_instr, v.expInstr);
    checkOutput({v.name, " rsp_addr"}, bus.rsp_addr, v.addr);
    checkOutput({v.name, " rsp_err"}, 32'(bus.rsp_err), v.expErr);
    tick();
    checkOutput({v.name, " consumed"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    int          accepted;
    int          respCount;
    logic [31:0] lastAddr;
    logic [31:0] lastInstr;
    logic [31:0] streamAddr  [4];
    logic [31:0] streamInstr [4];

    vectors[0] = '{addr: 32'h0000_0000, expInstr: 32'h0050_0093, expErr: 32'd0, name: "word0"};
    vectors[1] = '{addr: 32'h0000_0004, expInstr: 32'h00A0_0113, expErr: 32'd0, name: "word1"};
    vectors[2] = '{addr: 32'h0000_000C, expInstr: 32'h0020_81B3, expErr: 32'd0, name: "word3"};
    vectors[3] = '{addr: 32'h0000_3FFC, expInstr: 32'h1234_5678, expErr: 32'd0, name: "lastword"};
    vectors[4] = '{addr: 32'h0000_0002, expInstr: 32'h0000_0013, expErr: 32'd1, name: "misalign2"};
    vectors[5] = '{addr: 32'h0000_4000, expInstr: 32'h0000_0013, expErr: 32'd2, name: "range4000"};
    vectors[6] = '{addr: 32'h0000_0007, expInstr: 32'h0000_0013, expErr: 32'd1, name: "misalign7"};
    vectors[7] = '{addr: 32'hFFFF_FFF0, expInstr: 32'h0000_0013, expErr: 32'd2, name: "rangehigh"};
    vectors[8] = '{addr: 32'h0000_4001, expInstr: 32'h0000_0013, expErr: 32'd1, name: "misalignfirst"};

    streamAddr  = '{32'h0, 32'h4, 32'hC, 32'h3FFC};
    streamInstr = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3, 32'h1234_5678};

    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'h0;
    bus.flush     = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.load_en   = 1'b0;
    bus.load_addr = 32'h0;
    bus.load_data = 32'h0;

    // Reset state
    repeat (2) tick();
    checkOutput("reset req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("reset rsp_instr", bus.rsp_instr, 32'h0000_0013);
    checkOutput("reset rsp_addr", bus.rsp_addr, 32'h0);
    checkOutput("reset rsp_err", 32'(bus.rsp_err), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("ready waits for edge", 32'(bus.req_ready), 32'd0);
    tick();
    checkOutput("ready after release", 32'(bus.req_ready), 32'd1);

    // Program load; illegal loads alias word 0 and word 4095 and must be ignored
    bus.load_en   = 1'b1;
    bus.load_addr = 32'h0;
    bus.load_data = 32'h0050_0093;
    #1;
    checkOutput("ready low during load", 32'(bus.req_ready), 32'd0);
    tick();
    bus.load_en = 1'b0;
    loadWord(32'h0000_0004, 32'h00A0_0113);
    loadWord(32'h0000_000C, 32'h0020_81B3);
    loadWord(32'h0000_0040, 32'h0040_0113);
    loadWord(32'h0000_3FFC, 32'h1234_5678);
    loadWord(32'h0000_0002, 32'hBADB_AD01);
    loadWord(32'h0000_4000, 32'hBADB_AD02);
    loadWord(32'hFFFF_FFFC, 32'hBADB_AD03);

    // Back-to-back fetches at full throughput
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0;
    tick();
    bus.req_addr = 32'h4;
    tick();
    bus.req_valid = 1'b0;
    checkOutput("b2b not early", 32'(bus.rsp_valid), 32'd0);
    tick();
    checkOutput("b2b first valid", 32'(bus.rsp_valid), 32'd1);
    checkOutput("b2b first instr", bus.rsp_instr, 32'h0050_0093);
    checkOutput("b2b first addr", bus.rsp_addr, 32'h0);
    tick();
    checkOutput("b2b second valid", 32'(bus.rsp_valid), 32'd1);
    checkOutput("b2b second instr", bus.rsp_instr, 32'h00A0_0113);
    checkOutput("b2b second addr", bus.rsp_addr, 32'h4);
    tick();
    checkOutput("b2b drained", 32'(bus.rsp_valid), 32'd0);

    // Table-driven single fetches
    for (int i = 0; i < 9; i++) applyStimulus(vectors[i]);

    // Backpressure: only READ_LATENCY+1 requests may be accepted
    bus.rsp_ready = 1'b0;
    accepted      = 0;
    for (int c = 0; c < 8; c++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = streamAddr[(accepted < 4) ? accepted : 3];
      #1;
      if (bus.req_ready) accepted++;
      tick();
    end
    checkOutput("full accepted count", 32'(accepted), 32'(LAT + 1));
    checkOutput("full req_ready low", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < LAT + 1; i++) begin
      checkOutput($sformatf("drain%0d valid", i), 32'(bus.rsp_valid), 32'd1);
      checkOutput($sformatf("drain%0d addr", i), bus.rsp_addr, streamAddr[i]);
      checkOutput($sformatf("drain%0d instr", i), bus.rsp_instr, streamInstr[i]);
      tick();
      if (i == 0) checkOutput("ready after first pop", 32'(bus.req_ready), 32'd1);
    end
    checkOutput("drain no duplicate", 32'(bus.rsp_valid), 32'd0);

    // Flush with two in flight; the redirected fetch survives
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0;
    tick();
    bus.req_addr = 32'h4;
    tick();
    bus.req_addr = 32'h40;
    bus.flush    = 1'b1;
    tick();
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    respCount = 0;
    lastAddr  = 32'h0;
    lastInstr = 32'h0;
    for (int c = 0; c < 6; c++) begin
      if (bus.rsp_valid) begin
        respCount++;
        lastAddr  = bus.rsp_addr;
        lastInstr = bus.rsp_instr;
      end
      tick();
    end
    checkOutput("flush response count", 32'(respCount), 32'd1);
    checkOutput("flush response addr", lastAddr, 32'h40);
    checkOutput("flush response instr", lastInstr, 32'h0040_0113);

    // Reset while responses are buffered
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0;
    tick();
    bus.req_addr = 32'h4;
    tick();
    bus.req_valid = 1'b0;
    repeat (3) tick();
    checkOutput("pending before reset", 32'(bus.rsp_valid), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("reset drops rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("reset drops req_ready", 32'(bus.req_ready), 32'd0);
    repeat (2) tick();
    rst           = 1'b0;
    bus.rsp_ready = 1'b1;
    respCount     = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.rsp_valid) respCount++;
      tick();
    end
    checkOutput("no stale after reset", 32'(respCount), 32'd0);
    applyStimulus('{addr: 32'h4, expInstr: 32'h00A0_0113, expErr: 32'd0, name: "post-reset"});

    // Load then read the next cycle
    bus.load_en   = 1'b1;
    bus.load_addr = 32'h8;
    bus.load_data = 32'hDEAD_BEEF;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h8;
    #1;
    checkOutput("load blocks request", 32'(bus.req_ready), 32'd0);
    tick();
    bus.load_en = 1'b0;
    #1;
    checkOutput("ready after load", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    checkOutput("load read idle1", 32'(bus.rsp_valid), 32'd0);
    tick();
    checkOutput("load read idle2", 32'(bus.rsp_valid), 32'd0);
    tick();
    checkOutput("load read valid", 32'(bus.rsp_valid), 32'd1);
    checkOutput("load read instr", bus.rsp_instr, 32'hDEAD_BEEF);
    checkOutput("load read addr", bus.rsp_addr, 32'h8);
    tick();
    checkOutput("load read single", 32'(bus.rsp_valid), 32'd0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
